// File: rtl/chain_dpe_ctrl.sv
// chain_dpe_ctrl: job sequencer for one chain_dpe (skewed weight load, credit-limited
// activation streaming, result drain). Define DPE_CTRL_PERF_EN for busy/stall counters.
module chain_dpe_ctrl #(
  parameter int IDATAW         = 8,
  parameter int LANES          = 40,
  parameter int NUM_DSPS       = LANES / 4,
  parameter int BATCH          = 1,
  parameter int MAX_VECS       = 1024,
  parameter int RES_FIFO_DEPTH = 16,
  parameter int VW             = $clog2(MAX_VECS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [VW-1:0]           i_num_vecs,
  input  logic [LANES*IDATAW-1:0] i_wt_data,
  input  logic                    i_wt_valid,
  output logic                    o_wt_ready,
  input  logic [LANES*IDATAW-1:0] i_act_data,
  input  logic                    i_act_valid,
  output logic                    o_act_ready,
  output logic [LANES*IDATAW-1:0] o_dpe_data,
  output logic                    o_dpe_valid,
  output logic                    o_dpe_load,
  input  logic                    i_dpe_valid,
  input  logic                    i_res_pop,
`ifdef DPE_CTRL_PERF_EN
  output logic [31:0]             o_busy_cycles,
  output logic [31:0]             o_stall_cycles,
`endif
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int DW = LANES * IDATAW;
  localparam int GW = 4 * IDATAW;
  localparam int CW = $clog2(RES_FIFO_DEPTH + 1);
  localparam int LW = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam int SW = (NUM_DSPS > 2) ? $clog2(NUM_DSPS - 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SKEW, COMPUTE, FLUSH} state_t;

  state_t         state;
  logic [VW-1:0]  num_lat;
  logic [VW-1:0]  rem;
  logic [VW-1:0]  ret_cnt;
  logic [LW-1:0]  load_cnt;
  logic [SW-1:0]  skew_cnt;
  logic [CW-1:0]  credits;
  logic           wt_fire;
  logic           act_fire;
  logic           has_credit;
  logic           all_back;
  logic [DW-1:0]  skew_data;
  logic [DW-1:0]  mux_data;

  assign has_credit = credits != '0;
  assign wt_fire    = (state == LOAD) && i_wt_valid;
  assign act_fire   = (state == COMPUTE) && i_act_valid && has_credit;
  assign all_back   = ret_cnt == num_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      num_lat  <= '0;
      rem      <= '0;
      ret_cnt  <= '0;
      load_cnt <= '0;
      skew_cnt <= '0;
      credits  <= CW'(RES_FIFO_DEPTH);
    end else begin
      // An issue and a pop in the same cycle cancel; a pop at full credit is dropped.
      if (act_fire && !i_res_pop)
        credits <= credits - 1'b1;
      else if (!act_fire && i_res_pop && credits != CW'(RES_FIFO_DEPTH))
        credits <= credits + 1'b1;

      if (i_dpe_valid && state != IDLE)
        ret_cnt <= ret_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (i_start) begin
            num_lat  <= i_num_vecs;
            rem      <= i_num_vecs;
            load_cnt <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (wt_fire) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LW'(BATCH - 1)) begin
              skew_cnt <= '0;
              if (NUM_DSPS > 1)
                state <= SKEW;
              else
                state <= (num_lat == '0) ? FLUSH : COMPUTE;
            end
          end
        end
        SKEW: begin
          skew_cnt <= skew_cnt + 1'b1;
          if (skew_cnt == SW'(NUM_DSPS - 2))
            state <= (num_lat == '0) ? FLUSH : COMPUTE;
        end
        COMPUTE: begin
          if (act_fire) begin
            rem <= rem - 1'b1;
            if (rem == VW'(1))
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (all_back) begin
            ret_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Group g is delayed g cycles so the weight wavefront matches the DSP chain.
  assign skew_data[GW-1:0] = i_wt_data[GW-1:0];

  for (genvar g = 1; g < NUM_DSPS; g++) begin : g_skew
    localparam int unsigned DEPTH = g;
    logic [GW-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned k = 0; k < DEPTH; k++) sr[k] <= '0;
      end else begin
        sr[0] <= wt_fire ? i_wt_data[g*GW +: GW] : '0;
        for (int unsigned k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
    end

    assign skew_data[g*GW +: GW] = sr[DEPTH-1];
  end

  always_comb begin
    mux_data = i_act_data;
    if (state == LOAD || state == SKEW) begin
      mux_data = skew_data;
      if (!wt_fire) mux_data[GW-1:0] = i_act_data[GW-1:0];
    end
  end

  // Data path is forced low while reset is held so every output reads 0 immediately.
  assign o_dpe_data  = rst ? mux_data : '0;
  assign o_dpe_valid = wt_fire || act_fire;
  assign o_dpe_load  = wt_fire;
  assign o_wt_ready  = state == LOAD;
  assign o_act_ready = (state == COMPUTE) && has_credit;
  assign o_busy      = state != IDLE;
  assign o_done      = (state == FLUSH) && all_back;

`ifdef DPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_busy_cycles  <= '0;
      o_stall_cycles <= '0;
    end else if (state == IDLE && i_start) begin
      o_busy_cycles  <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (state != IDLE && o_busy_cycles != '1)
        o_busy_cycles <= o_busy_cycles + 1'b1;
      if (state == COMPUTE && i_act_valid && !has_credit && o_stall_cycles != '1)
        o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end
`endif

endmodule
